// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline control block: the sequencer state
// encoding and the default timing parameters.
`timescale 1ns/1ps
package pipe_ctrl_pkg;

  localparam int unsigned DRAIN_CYCLES_DEF = 3;
  localparam int unsigned IMEM_TIMEOUT_DEF = 16;
  localparam int unsigned CNT_W_DEF        = 16;
  localparam int unsigned STATE_W          = 3;
  localparam int unsigned REG_W            = 5;

  typedef enum logic [STATE_W-1:0] {
    ST_INIT      = 3'd0,
    ST_RUN       = 3'd1,
    ST_IMEM_WAIT = 3'd2,
    ST_DRAIN     = 3'd3,
    ST_HALTED    = 3'd4,
    ST_FAULT     = 3'd5
  } seq_state_e;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detector: flags when the load in EX writes a register
// that the instruction in ID reads. Purely combinational.
// Ports:
//   ex_mem_read_i   EX instruction is a load
//   ex_rd_i         EX destination register
//   id_rs_i/id_rt_i ID source registers
//   id_uses_rt_i    ID instruction actually reads rt
//   load_use_o      hazard present this cycle
`timescale 1ns/1ps
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic             ex_mem_read_i,
  input  logic [REG_W-1:0] ex_rd_i,
  input  logic [REG_W-1:0] id_rs_i,
  input  logic [REG_W-1:0] id_rt_i,
  input  logic             id_uses_rt_i,
  output logic             load_use_o
);

  // r0 is hardwired zero, so a load targeting it never creates a hazard.
  assign load_use_o = ex_mem_read_i && (ex_rd_i != '0) &&
                      ((ex_rd_i == id_rs_i) || (id_uses_rt_i && (ex_rd_i == id_rt_i)));

endmodule

// File: rtl/pipeline_sequencer.sv
// Pipeline sequencer: controls PC/nPC/IF-ID load enables and ID/EX bubble
// insertion for load-use stalls, instruction-memory waits (with timeout
// fault) and a halt/drain sequence. Counts stall cycles.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   imem_ready                 fetch word valid this cycle
//   id_rs, id_rt, id_uses_rt   ID-stage source operands
//   ex_mem_read, ex_rd         EX-stage load and its destination
//   branch_taken               ID instruction is a taken branch/jump
//   halt_req                   level request to stop and drain
//   le_pc, le_npc, le_ifid     load enables (same-cycle)
//   ex_bubble                  zero the ID/EX control word (same-cycle)
//   npc_sel                    0 = nPC+4, 1 = branch target (same-cycle)
//   halted, fault, state       status
//   stall_cnt                  saturating count of stalled RUN cycles
`timescale 1ns/1ps
module pipeline_sequencer
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned DRAIN_CYCLES = DRAIN_CYCLES_DEF,
  parameter int unsigned IMEM_TIMEOUT = IMEM_TIMEOUT_DEF,
  parameter int unsigned CNT_W        = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               imem_ready,
  input  logic [REG_W-1:0]   id_rs,
  input  logic [REG_W-1:0]   id_rt,
  input  logic               id_uses_rt,
  input  logic               ex_mem_read,
  input  logic [REG_W-1:0]   ex_rd,
  input  logic               branch_taken,
  input  logic               halt_req,
  output logic               le_pc,
  output logic               le_npc,
  output logic               le_ifid,
  output logic               ex_bubble,
  output logic               npc_sel,
  output logic               halted,
  output logic               fault,
  output logic [STATE_W-1:0] state,
  output logic [CNT_W-1:0]   stall_cnt
);

  localparam int unsigned WAIT_W  = (IMEM_TIMEOUT < 2) ? 1 : $clog2(IMEM_TIMEOUT + 1);
  localparam int unsigned DRAIN_W = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);

  seq_state_e         state_q, state_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic [DRAIN_W-1:0] drain_q, drain_d;
  logic [CNT_W-1:0]   stall_q, stall_d;
  logic               halted_q, halted_d;
  logic               fault_q, fault_d;

  logic load_use;
  logic advance;
  logic le_c, bubble_c, npc_sel_c;

  hazard_detect u_hazard (
    .ex_mem_read_i (ex_mem_read),
    .ex_rd_i       (ex_rd),
    .id_rs_i       (id_rs),
    .id_rt_i       (id_rt),
    .id_uses_rt_i  (id_uses_rt),
    .load_use_o    (load_use)
  );

  assign advance = imem_ready && !load_use;

  // Next-state and same-cycle control outputs.
  always_comb begin
    state_d   = state_q;
    wait_d    = '0;
    drain_d   = drain_q;
    stall_d   = stall_q;
    le_c      = 1'b0;
    bubble_c  = 1'b1;
    npc_sel_c = 1'b0;

    case (state_q)
      ST_INIT: state_d = ST_RUN;

      ST_RUN, ST_IMEM_WAIT: begin
        le_c      = advance;
        bubble_c  = !advance;
        npc_sel_c = branch_taken && advance;
        if (!advance && (stall_q != {CNT_W{1'b1}})) begin
          stall_d = stall_q + CNT_W'(1);
        end
        if (!imem_ready) begin
          wait_d = wait_q + WAIT_W'(1);
        end
        // Halt wins over both the wait and the timeout transitions.
        if (halt_req) begin
          state_d = ST_DRAIN;
          drain_d = DRAIN_W'(DRAIN_CYCLES);
        end else if (!imem_ready) begin
          state_d = (wait_d == WAIT_W'(IMEM_TIMEOUT)) ? ST_FAULT : ST_IMEM_WAIT;
        end else begin
          state_d = ST_RUN;
        end
      end

      ST_DRAIN: begin
        if (drain_q > DRAIN_W'(1)) begin
          drain_d = drain_q - DRAIN_W'(1);
        end else begin
          drain_d = '0;
          state_d = halt_req ? ST_HALTED : ST_RUN;
        end
      end

      ST_HALTED: begin
        if (!halt_req) begin
          state_d = ST_RUN;
        end
      end

      ST_FAULT: state_d = ST_FAULT;

      default: state_d = ST_INIT;
    endcase

    halted_d = (state_d == ST_HALTED);
    fault_d  = (state_d == ST_FAULT);

    // Reset forces a safe, frozen pipeline in the same cycle.
    if (reset) begin
      le_c      = 1'b0;
      bubble_c  = 1'b1;
      npc_sel_c = 1'b0;
    end
  end

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_INIT;
      wait_q   <= '0;
      drain_q  <= '0;
      stall_q  <= '0;
      halted_q <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      drain_q  <= drain_d;
      stall_q  <= stall_d;
      halted_q <= halted_d;
      fault_q  <= fault_d;
    end
  end

  assign le_pc     = le_c;
  assign le_npc    = le_c;
  assign le_ifid   = le_c;
  assign ex_bubble = bubble_c;
  assign npc_sel   = npc_sel_c;
  assign halted    = halted_q;
  assign fault     = fault_q;
  assign state     = state_q;
  assign stall_cnt = stall_q;

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Self-checking bench for pipeline_sequencer: directed scenarios plus a
// randomized run checked against a cycle-level behavioural model.
`timescale 1ns/1ps
module tb_pipeline_sequencer;

  localparam int DRAIN_N  = 3;
  localparam int TIMEOUT  = 16;
  localparam int STALL_MX = 65535;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_ready;
  logic [4:0]  id_rs, id_rt, ex_rd;
  logic        id_uses_rt, ex_mem_read, branch_taken, halt_req;
  logic        le_pc, le_npc, le_ifid, ex_bubble, npc_sel, halted, fault;
  logic [2:0]  state;
  logic [15:0] stall_cnt;

  int checks   = 0;
  int failures = 0;
  int exp_stall;

  // behavioural model state
  int m_state, m_wait, m_drain, m_stall;

  always #5 clk = ~clk;

  pipeline_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .imem_ready   (imem_ready),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_uses_rt   (id_uses_rt),
    .ex_mem_read  (ex_mem_read),
    .ex_rd        (ex_rd),
    .branch_taken (branch_taken),
    .halt_req     (halt_req),
    .le_pc        (le_pc),
    .le_npc       (le_npc),
    .le_ifid      (le_ifid),
    .ex_bubble    (ex_bubble),
    .npc_sel      (npc_sel),
    .halted       (halted),
    .fault        (fault),
    .state        (state),
    .stall_cnt    (stall_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    imem_ready = 1'b1; id_rs = 5'd0; id_rt = 5'd0; ex_rd = 5'd0;
    id_uses_rt = 1'b0; ex_mem_read = 1'b0; branch_taken = 1'b0; halt_req = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    exp_stall = 0;
  endtask

  function automatic bit model_hazard();
    return ex_mem_read && (ex_rd != 0) &&
           (ex_rd == id_rs || (id_uses_rt && ex_rd == id_rt));
  endfunction

  // Advance the model by one clock edge using the current inputs.
  task automatic model_step();
    bit adv;
    adv = imem_ready && !model_hazard();
    if (reset) begin
      m_state = 0; m_wait = 0; m_drain = 0; m_stall = 0;
    end else if (m_state == 1 || m_state == 2) begin
      if (!adv && m_stall < STALL_MX) m_stall++;
      m_wait = imem_ready ? 0 : m_wait + 1;
      if (halt_req) begin
        m_state = 3; m_drain = DRAIN_N;
      end else if (!imem_ready) begin
        m_state = (m_wait >= TIMEOUT) ? 5 : 2;
      end else begin
        m_state = 1;
      end
    end else begin
      m_wait = 0;
      if (m_state == 0) m_state = 1;
      else if (m_state == 3) begin
        m_drain--;
        if (m_drain == 0) m_state = halt_req ? 4 : 1;
      end else if (m_state == 4) begin
        if (!halt_req) m_state = 1;
      end
    end
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b1;
    tick(); tick();
    checks++; if (le_pc !== 1'b0 || le_npc !== 1'b0 || le_ifid !== 1'b0) begin failures++; $display("FAIL reset_le: got %b%b%b want 000", le_pc, le_npc, le_ifid); end
    checks++; if (ex_bubble !== 1'b1 || npc_sel !== 1'b0) begin failures++; $display("FAIL reset_bubble_sel: got bubble=%b sel=%b want 1/0", ex_bubble, npc_sel); end
    checks++; if (state !== 3'd0 || halted !== 1'b0 || fault !== 1'b0 || stall_cnt !== 16'd0) begin failures++; $display("FAIL reset_regs: got state=%0d h=%b f=%b stall=%0d want 0/0/0/0", state, halted, fault, stall_cnt); end
    reset = 1'b0;
    #1;
    checks++; if (state !== 3'd0 || le_pc !== 1'b0) begin failures++; $display("FAIL init_cycle: got state=%0d le_pc=%b want 0/0", state, le_pc); end
    tick();
    checks++; if (state !== 3'd1 || le_pc !== 1'b1 || ex_bubble !== 1'b0) begin failures++; $display("FAIL run_after_init: got state=%0d le_pc=%b bub=%b want 1/1/0", state, le_pc, ex_bubble); end
    exp_stall = 0;
  endtask

  task automatic test_load_use();
    ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs = 5'd5;
    #1;
    checks++; if (le_pc !== 1'b0 || le_ifid !== 1'b0 || ex_bubble !== 1'b1) begin failures++; $display("FAIL lu_rs_stall: got le_pc=%b le_ifid=%b bub=%b want 0/0/1", le_pc, le_ifid, ex_bubble); end
    tick(); exp_stall++;
    checks++; if (stall_cnt !== 16'(exp_stall)) begin failures++; $display("FAIL lu_stall_cnt: got %0d want %0d", stall_cnt, exp_stall); end
    ex_rd = 5'd0; id_rs = 5'd0;
    #1;
    checks++; if (le_pc !== 1'b1 || ex_bubble !== 1'b0) begin failures++; $display("FAIL lu_r0_no_stall: got le_pc=%b bub=%b want 1/0", le_pc, ex_bubble); end
    tick();
    checks++; if (stall_cnt !== 16'(exp_stall)) begin failures++; $display("FAIL lu_r0_cnt: got %0d want %0d", stall_cnt, exp_stall); end
    ex_rd = 5'd7; id_rs = 5'd3; id_rt = 5'd7; id_uses_rt = 1'b0;
    #1;
    checks++; if (le_pc !== 1'b1) begin failures++; $display("FAIL lu_rt_unused: got le_pc=%b want 1", le_pc); end
    id_uses_rt = 1'b1;
    #1;
    checks++; if (le_pc !== 1'b0 || ex_bubble !== 1'b1) begin failures++; $display("FAIL lu_rt_used: got le_pc=%b bub=%b want 0/1", le_pc, ex_bubble); end
    tick(); exp_stall++;
    clear_inputs();
  endtask

  task automatic test_branch_hold();
    branch_taken = 1'b1; ex_mem_read = 1'b1; ex_rd = 5'd9; id_rs = 5'd9;
    #1;
    checks++; if (npc_sel !== 1'b0 || le_npc !== 1'b0) begin failures++; $display("FAIL br_hazard: got sel=%b le_npc=%b want 0/0", npc_sel, le_npc); end
    tick(); exp_stall++;
    ex_mem_read = 1'b0;
    #1;
    checks++; if (npc_sel !== 1'b1 || le_npc !== 1'b1) begin failures++; $display("FAIL br_resume: got sel=%b le_npc=%b want 1/1", npc_sel, le_npc); end
    tick();
    checks++; if (stall_cnt !== 16'(exp_stall)) begin failures++; $display("FAIL br_stall_cnt: got %0d want %0d", stall_cnt, exp_stall); end
    clear_inputs();
  endtask

  task automatic test_imem_timeout();
    imem_ready = 1'b0;
    #1;
    checks++; if (le_pc !== 1'b0 || ex_bubble !== 1'b1) begin failures++; $display("FAIL imem_stall: got le_pc=%b bub=%b want 0/1", le_pc, ex_bubble); end
    repeat (TIMEOUT - 1) tick();
    exp_stall += TIMEOUT - 1;
    checks++; if (state !== 3'd2 || fault !== 1'b0) begin failures++; $display("FAIL imem_15: got state=%0d fault=%b want 2/0", state, fault); end
    imem_ready = 1'b1;
    #1;
    checks++; if (le_pc !== 1'b1) begin failures++; $display("FAIL imem_resume_le: got %b want 1", le_pc); end
    tick();
    checks++; if (state !== 3'd1 || fault !== 1'b0 || stall_cnt !== 16'(exp_stall)) begin failures++; $display("FAIL imem_resume: got state=%0d fault=%b stall=%0d want 1/0/%0d", state, fault, stall_cnt, exp_stall); end
    imem_ready = 1'b0;
    repeat (TIMEOUT - 1) tick();
    checks++; if (state !== 3'd2) begin failures++; $display("FAIL imem_pre_fault: got state=%0d want 2", state); end
    tick();
    checks++; if (state !== 3'd5 || fault !== 1'b1) begin failures++; $display("FAIL imem_fault: got state=%0d fault=%b want 5/1", state, fault); end
    imem_ready = 1'b1;
    repeat (4) tick();
    checks++; if (state !== 3'd5 || fault !== 1'b1 || le_pc !== 1'b0 || ex_bubble !== 1'b1) begin failures++; $display("FAIL fault_sticky: got state=%0d fault=%b le=%b bub=%b want 5/1/0/1", state, fault, le_pc, ex_bubble); end
    do_reset();
    checks++; if (state !== 3'd1 || fault !== 1'b0 || stall_cnt !== 16'd0) begin failures++; $display("FAIL fault_cleared: got state=%0d fault=%b stall=%0d want 1/0/0", state, fault, stall_cnt); end
  endtask

  task automatic test_halt_drain();
    halt_req = 1'b1;
    #1;
    checks++; if (le_pc !== 1'b1 || ex_bubble !== 1'b0) begin failures++; $display("FAIL halt_cur_cycle: got le=%b bub=%b want 1/0", le_pc, ex_bubble); end
    tick();
    for (int i = 0; i < DRAIN_N; i++) begin
      checks++; if (state !== 3'd3 || ex_bubble !== 1'b1 || le_pc !== 1'b0 || halted !== 1'b0) begin failures++; $display("FAIL drain_%0d: got state=%0d bub=%b le=%b h=%b want 3/1/0/0", i, state, ex_bubble, le_pc, halted); end
      tick();
    end
    checks++; if (state !== 3'd4 || halted !== 1'b1) begin failures++; $display("FAIL halted: got state=%0d h=%b want 4/1", state, halted); end
    tick();
    checks++; if (state !== 3'd4 || halted !== 1'b1 || ex_bubble !== 1'b1) begin failures++; $display("FAIL halted_hold: got state=%0d h=%b bub=%b want 4/1/1", state, halted, ex_bubble); end
    halt_req = 1'b0;
    tick();
    checks++; if (state !== 3'd1 || halted !== 1'b0 || le_pc !== 1'b1) begin failures++; $display("FAIL unhalt: got state=%0d h=%b le=%b want 1/0/1", state, halted, le_pc); end
  endtask

  task automatic test_stall_saturation();
    do_reset();
    ex_mem_read = 1'b1; ex_rd = 5'd4; id_rs = 5'd4;
    repeat (STALL_MX + 4) tick();
    checks++; if (stall_cnt !== 16'hFFFF || state !== 3'd1) begin failures++; $display("FAIL stall_sat: got stall=%0h state=%0d want ffff/1", stall_cnt, state); end
    tick();
    checks++; if (stall_cnt !== 16'hFFFF) begin failures++; $display("FAIL stall_sat_hold: got %0h want ffff", stall_cnt); end
    halt_req = 1'b1;
    tick(); tick();
    checks++; if (state !== 3'd3) begin failures++; $display("FAIL mid_drain: got state=%0d want 3", state); end
    reset = 1'b1;
    tick();
    checks++; if (state !== 3'd0 || stall_cnt !== 16'd0 || halted !== 1'b0) begin failures++; $display("FAIL reset_mid_drain: got state=%0d stall=%0d h=%b want 0/0/0", state, stall_cnt, halted); end
    reset = 1'b0;
    clear_inputs();
    tick();
  endtask

  task automatic test_random();
    bit e_adv, e_le, e_bub, e_sel;
    reset = 1'b1;
    for (int n = 0; n < 1500; n++) begin
      if (n > 0) begin
        reset        = ($urandom_range(0, 99) < 2);
        // bursts of not-ready so the timeout path is occasionally reached
        imem_ready   = (n % 200 < 20) ? 1'b0 : ($urandom_range(0, 99) < 80);
        ex_mem_read  = $urandom_range(0, 1);
        ex_rd        = 5'($urandom_range(0, 3));
        id_rs        = 5'($urandom_range(0, 3));
        id_rt        = 5'($urandom_range(0, 3));
        id_uses_rt   = $urandom_range(0, 1);
        branch_taken = $urandom_range(0, 1);
        if ($urandom_range(0, 99) < 8) halt_req = ~halt_req;
      end
      #1;
      e_adv = imem_ready && !model_hazard();
      if (reset || !(m_state == 1 || m_state == 2)) begin
        e_le = 1'b0; e_bub = 1'b1; e_sel = 1'b0;
      end else begin
        e_le = e_adv; e_bub = !e_adv; e_sel = branch_taken && e_adv;
      end
      if (n > 0) begin
        checks++; if (le_pc !== e_le || le_npc !== e_le || le_ifid !== e_le) begin failures++; $display("FAIL rnd_le n=%0d: got %b%b%b want %b", n, le_pc, le_npc, le_ifid, e_le); end
        checks++; if (ex_bubble !== e_bub || npc_sel !== e_sel) begin failures++; $display("FAIL rnd_bub_sel n=%0d: got %b/%b want %b/%b", n, ex_bubble, npc_sel, e_bub, e_sel); end
        checks++; if (state !== 3'(m_state) || halted !== (m_state == 4) || fault !== (m_state == 5)) begin failures++; $display("FAIL rnd_state n=%0d: got %0d h=%b f=%b want %0d", n, state, halted, fault, m_state); end
        checks++; if (stall_cnt !== 16'(m_stall)) begin failures++; $display("FAIL rnd_stall n=%0d: got %0d want %0d", n, stall_cnt, m_stall); end
      end
      tick();
      model_step();
    end
    clear_inputs();
    do_reset();
  endtask

  initial begin
    m_state = 0; m_wait = 0; m_drain = 0; m_stall = 0;
    exp_stall = 0;
    reset = 1'b1;
    clear_inputs();
    #2;
    test_reset();
    test_load_use();
    test_branch_hold();
    test_imem_timeout();
    test_halt_drain();
    test_stall_saturation();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipeline_sequencer.md
PIPELINE_SEQUENCER -- requirements
Module: pipeline_sequencer

Interface
REQ-001 SHALL have parameter DRAIN_CYCLES, default 3, meaning the number of bubble cycles needed to empty EX/MEM/WB.
REQ-002 SHALL have parameter IMEM_TIMEOUT, default 16, meaning the count of consecutive not-ready fetch cycles that triggers a fault.
REQ-003 SHALL have parameter CNT_W, default 16, meaning the stall counter width.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port imem_ready, input, 1 bit: the instruction memory word at PC is valid this cycle.
REQ-007 SHALL have ports id_rs and id_rt, input, 5 bits each: source registers of the instruction in ID.
REQ-008 SHALL have port id_uses_rt, input, 1 bit: the ID instruction reads rt.
REQ-009 SHALL have ports ex_mem_read (1 bit) and ex_rd (5 bits), inputs: the EX instruction is a load, and its destination register.
REQ-010 SHALL have port branch_taken, input, 1 bit: the ID instruction is a taken branch or jump (delayed branch).
REQ-011 SHALL have port halt_req, input, 1 bit: a level request to stop fetch and drain the pipeline.
REQ-012 SHALL have ports le_pc, le_npc and le_ifid, output, 1 bit each: load enables for PC, nPC and the IF/ID register.
REQ-013 SHALL have port ex_bubble, output, 1 bit: forces all-zero control into ID/EX.
REQ-014 SHALL have port npc_sel, output, 1 bit: 0 = nPC+4, 1 = branch target.
REQ-015 SHALL have ports halted and fault, output, 1 bit each, plus port state, output, 3 bits.
REQ-016 SHALL have port stall_cnt, output, CNT_W bits.

Function
REQ-017 SHALL implement states INIT=0, RUN=1, IMEM_WAIT=2, DRAIN=3, HALTED=4, FAULT=5, and drive state with the current encoding.
REQ-018 SHALL compute load_use combinationally as ex_mem_read && ex_rd!=0 && (ex_rd==id_rs || (id_uses_rt && ex_rd==id_rt)).
REQ-019 SHALL, in RUN and IMEM_WAIT, define advance = imem_ready && !load_use.
REQ-020 SHALL, in RUN and IMEM_WAIT, drive le_pc = le_npc = le_ifid = advance and ex_bubble = !advance, all in the same cycle as the inputs.
REQ-021 SHALL drive npc_sel = branch_taken && advance; PC always loads the old nPC (delay slot).
REQ-022 SHALL, in INIT, DRAIN, HALTED and FAULT, drive le_pc = le_npc = le_ifid = 0 and ex_bubble = 1.
REQ-023 SHALL make INIT last exactly one cycle and then move to RUN.
REQ-024 SHALL keep wait_cnt, which increments on each imem_ready=0 cycle in RUN/IMEM_WAIT and clears on imem_ready=1.
REQ-025 SHALL have RUN move to IMEM_WAIT when imem_ready=0, and IMEM_WAIT return to RUN when imem_ready=1.
REQ-026 SHALL move to FAULT on the edge where wait_cnt reaches IMEM_TIMEOUT; FAULT is sticky until reset, and fault = 1 there.
REQ-027 SHALL have halt_req=1 in RUN/IMEM_WAIT select DRAIN as the next state (priority over IMEM_WAIT/FAULT transitions); the current cycle still obeys REQ-020.
REQ-028 SHALL have DRAIN last DRAIN_CYCLES cycles (counter loaded on entry), ignore imem_ready, and then go to HALTED if halt_req=1, else RUN.
REQ-029 SHALL assert halted=1 only in HALTED; halt_req=0 in HALTED selects RUN next.
REQ-030 SHALL increment stall_cnt on each RUN/IMEM_WAIT cycle with advance=0, saturating at all-ones, and clear it only on reset.
REQ-031 SHALL leave the ID instruction held (not lost) across load-use, IMEM and halt stalls, so branch_taken is re-evaluated on resume.

Reset
REQ-032 SHALL, on reset=1 at a clock edge, set state=INIT, wait_cnt=0, drain counter=0, stall_cnt=0, halted=0 and fault=0, overriding any state, including FAULT or mid-DRAIN.
REQ-033 SHALL drive le_pc = le_npc = le_ifid = 0, ex_bubble = 1 and npc_sel = 0 while reset is high.

Structure
REQ-034 SHALL take the state enum, DRAIN_CYCLES and IMEM_TIMEOUT defaults from shared package pipe_ctrl_pkg.
REQ-035 SHALL place the REQ-018 compare in a combinational sub-module named hazard_detect.

Verification
REQ-036 SHALL cover: reset release with imem_ready=1 -> state 0 for 1 cycle, then 1; le_pc=1 from the 2nd cycle.
REQ-037 SHALL cover: ex_mem_read=1, ex_rd=5, id_rs=5 -> le_pc=le_ifid=0, ex_bubble=1, stall_cnt +1; the same with ex_rd=0 -> no stall.
REQ-038 SHALL cover: branch_taken=1 together with a load-use hazard -> npc_sel=0; next cycle, hazard cleared -> npc_sel=1, le_npc=1.
REQ-039 SHALL cover: imem_ready=0 for 15 cycles, then 1 -> state 2 then 1, fault=0; for 16 cycles -> state 5, fault=1, held until reset.
REQ-040 SHALL cover: halt_req=1 in RUN -> 3 DRAIN cycles with ex_bubble=1, then halted=1; halt_req=0 -> RUN next cycle.
REQ-041 SHALL cover: stall_cnt preloaded near all-ones with continuous stall -> holds at 0xFFFF; reset mid-DRAIN -> state 0, stall_cnt=0.
